// File: rtl/vga_buf_pkg.sv
// Shared definitions for the ping-pong line-buffer controller:
// read FSM encoding, default counter width and the bank address helper.
package vga_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned CNT_W          = ADDR_WIDTH_DEF - 1;

  // Bank bit sits directly above the cnt_w-bit pixel count.
  function automatic logic [31:0] bank_addr(input logic        bank,
                                            input logic [30:0] cnt,
                                            input int unsigned cnt_w);
    return ({31'd0, bank} << cnt_w) | {1'b0, cnt};
  endfunction

endpackage

// File: rtl/vga_buffer_ctrl.sv
// Ping-pong line-buffer controller: fills the free RAM bank from the pixel
// stream and plays full banks out with valid/ready backpressure.
module vga_buffer_ctrl
  import vga_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned LINE_LEN   = 1024
) (
  input  logic                  vga_clk,
  input  logic                  vga_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            lines_buffered
);

  localparam int unsigned CW = ADDR_WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);

  rd_state_e     state_q, state_d;
  logic          rst_q;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    lines_q, lines_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          set_full, clr_full;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    set_full  = 1'b0;
    clr_full  = 1'b0;
    mem_rd_en = 1'b0;

    in_ready  = !rst_q && !full_q[wr_bank_q];
    mem_wr_en = in_valid && in_ready;

    if (mem_wr_en) begin
      if (wcnt_q == LAST) begin
        wcnt_d    = '0;
        wr_bank_d = !wr_bank_q;
        set_full  = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = READ;
          rcnt_d  = '0;
        end
      end
      READ: begin
        mem_rd_en = !out_valid_q || out_ready;
        if (mem_rd_en) begin
          if (rcnt_q == LAST) state_d = DRAIN;
          else                rcnt_d  = rcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          clr_full  = 1'b1;
          rd_bank_d = !rd_bank_q;
          rcnt_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set and clear never target the same bank, so applying both is safe.
    full_d = full_q;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q] = 1'b1;
    lines_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};

    out_valid_d = mem_rd_en || (out_valid_q && !out_ready);
    out_last_d  = (mem_rd_en && (rcnt_q == LAST)) ||
                  (out_last_q && out_valid_q && !out_ready);
  end

  always_ff @(posedge vga_clk) begin
    rst_q <= vga_rst;
    if (vga_rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      full_q      <= '0;
      lines_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      full_q      <= full_d;
      lines_q     <= lines_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign mem_wdata      = in_data;
  assign mem_waddr      = ADDR_WIDTH'(bank_addr(wr_bank_q, 31'(wcnt_q), CW));
  assign mem_raddr      = ADDR_WIDTH'(bank_addr(rd_bank_q, 31'(rcnt_q), CW));
  assign out_data       = mem_rdata;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign lines_buffered = lines_q;

endmodule

// File: doc/vga_buffer_ctrl.md
Name: vga_buffer_ctrl

Overview:
- Single-clock ping-pong line-buffer controller that sequences a simple dual-port RAM (registered read, 1-cycle latency, read-enable-gated output register) used as two line banks.
- Accepts an incoming pixel stream one line at a time and writes it into the free bank.
- Plays completed lines out to the display side with valid/ready backpressure.
- Sits between the camera/frame-buffer pixel stream and the HDMI/VGA timing path; the RAM itself is instantiated alongside with RAM_DEPTH = 2*LINE_LEN.

Parameters:
- DATA_WIDTH, 24, pixel width in bits.
- ADDR_WIDTH, 11, RAM address width; MSB selects the bank.
- LINE_LEN, 1024, pixels per line; must satisfy 2 <= LINE_LEN <= 2^(ADDR_WIDTH-1).

Ports:
- vga_clk  in  1  single clock for all logic and both RAM ports.
- vga_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_WIDTH  input pixel.
- in_ready  out  1  controller can accept a pixel this cycle.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_WIDTH  output pixel; wired directly to mem_rdata.
- out_last  out  1  marks the final pixel of a line.
- out_ready  in  1  downstream accepts the pixel.
- mem_wdata  out  DATA_WIDTH  RAM write data; equals in_data.
- mem_waddr  out  ADDR_WIDTH  RAM write address, formed as {wr_bank, wcnt} zero-padded.
- mem_wr_en  out  1  RAM write enable.
- mem_raddr  out  ADDR_WIDTH  RAM read address, formed as {rd_bank, rcnt}.
- mem_rd_en  out  1  RAM read enable.
- mem_rdata  in  DATA_WIDTH  RAM registered read data.
- lines_buffered  out  2  number of full banks, 0..2.

Behaviour:
- Reset (vga_rst=1 on a rising edge):
  - wr_bank=0, rd_bank=0, wcnt=0, rcnt=0, full[1:0]=0, FSM=IDLE.
  - out_valid=0, out_last=0, in_ready=0 during reset; lines_buffered=0.
  - Reset asserted mid-line discards all partial and buffered lines; RAM contents are not cleared.
- Write side:
  - in_ready = !vga_rst_q & !full[wr_bank], where vga_rst_q is the registered reset.
  - mem_wr_en = in_valid & in_ready.
  - On each write: wcnt++.
  - When wcnt==LINE_LEN-1 on a write: set full[wr_bank], toggle wr_bank, wcnt=0.
- Read FSM, states IDLE / READ / DRAIN:
  - IDLE: if full[rd_bank] -> READ with rcnt=0.
  - READ: mem_rd_en = !out_valid | out_ready; each issued read does rcnt++.
    - A read issued with rcnt==LINE_LEN-1 -> DRAIN.
  - DRAIN: mem_rd_en=0. When out_valid & out_ready & out_last: clear full[rd_bank], toggle rd_bank, rcnt=0, -> IDLE.
- Output register tracking:
  - out_valid <= mem_rd_en | (out_valid & !out_ready).
  - out_last <= (mem_rd_en & rcnt==LINE_LEN-1) | (out_last & out_valid & !out_ready).
  - The RAM output holds while mem_rd_en=0, so out_data stays stable under backpressure. No skid buffer is needed.
- Latency:
  - First pixel of a line appears on out_valid 2 cycles after the final write of that line: 1 cycle for full to set and IDLE->READ, 1 cycle of RAM latency.
  - Sustained throughput is 1 pixel/cycle when out_ready=1.
- Simultaneous events:
  - A write completion setting full[x] and a drain completion clearing full[y] in the same cycle are always on different banks; both take effect.
  - With both banks full, in_ready=0 until a drain completes. in_ready rises the cycle after the clear.
- lines_buffered = full[0]+full[1], registered along with full.
- Wrap-around: counters return to 0 exactly at LINE_LEN-1, never at 2^n unless the two are equal.

Decomposition:
- Shared package vga_buf_pkg:
  - read FSM state encoding (IDLE=2'd0, READ=2'd1, DRAIN=2'd2);
  - localparam CNT_W = ADDR_WIDTH-1;
  - helper function computing a bank address from bank bit and count.
- No sub-module. The RAM stays a separate sibling instance wired at the parent level.

Test Plan (LINE_LEN=4, ADDR_WIDTH=3, DATA_WIDTH=8 unless noted):
- Single line: write 0x10..0x13 with out_ready=1. Required: mem_waddr 0..3; out_data 0x10..0x13 starting 2 cycles after the last write; out_last only on 0x13; lines_buffered pulses 1 then returns to 0.
- Back-to-back lines with out_ready=0: write 8 pixels. Required: mem_waddr 0..3 then 4..7; in_ready=0 after the 8th pixel; lines_buffered=2; a 9th pixel is not accepted.
- Backpressure: out_ready toggles 1,0,0,1,... during readout. Required: out_data is held while out_ready=0, no pixel is dropped or duplicated, and mem_rd_en=0 in every stalled cycle.
- Concurrent fill/drain: continuous input with out_ready=1 over 6 lines. Required: output order equals input order; in_ready never deasserts for more than one line time; banks alternate 0,1,0,...
- Mid-operation reset: assert vga_rst after 2 pixels of line 2 while line 1 is draining. Required: next cycle out_valid=0, lines_buffered=0, in_ready=0; after release the next written line is output from bank 0 with address 0..3.
- Boundary: LINE_LEN=3, ADDR_WIDTH=3. Required: wcnt wraps at 2, not at 3; addresses 0,1,2 then 4,5,6.
